// File: rtl/osd_ctm_sampler_if.sv
// ---------------------------------------------------------------------------
// osd_ctm_sampler_if
//
// Output stream of the trace sampler towards the trace packetizer. This is a
// plain valid/ready stream of fixed-width event words.
//
// Parameters:
//   EW         width of one event word
//
// Signals:
//   out_data   event word at the head of the sampler FIFO
//   out_valid  out_data holds a valid record
//   out_ready  the consumer accepts out_data in this cycle
//
// Modports:
//   master     sampler side (drives data/valid, observes ready)
//   slave      packetizer side (observes data/valid, drives ready)
// ---------------------------------------------------------------------------
interface osd_ctm_sampler_if #(
    parameter int EW = 165
);
    logic [EW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/osd_ctm_sampler.sv
// ---------------------------------------------------------------------------
// osd_ctm_sampler
//
// Trace-capture front end of the core trace module. It watches the core's
// retirement trace, picks at most one event per cycle (jal, jalr, taken
// branch, trap, exception, privilege change), filters it against a runtime
// kind mask and an optional inclusive PC window, timestamps it and buffers it
// in a DEPTH-entry first-word-fall-through FIFO. Events that find the FIFO
// full are counted, and the count is later pushed as an overflow record
// (kind 3'b111) ahead of any newer event.
//
// Parameters:
//   ADDR_WIDTH  width of trace_pc / trace_npc / window bounds
//   TS_WIDTH    width of the free-running timestamp
//   DEPTH       FIFO entries, power of two, >= 2
//   OVF_WIDTH   dropped-event counter width, <= EW-3
//   EW, LW      derived: event word width, FIFO level width
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cfg_enable                  sampling enable
//   cfg_mask[5:0]               per-kind enable, indexed by kind
//   cfg_range_en                enable the PC window filter
//   cfg_addr_lo, cfg_addr_hi    inclusive PC window bounds
//   stall                       debug-system stall, suppresses new events
//   trace_*                     core retirement trace strobes / PC / privilege
//   out_if                      event stream (out_data/out_valid/out_ready)
//   fifo_level                  current FIFO occupancy
//   drop_cnt                    pending dropped-event count
//
// Event word layout: {kind[2:0], prv[1:0], pc, npc, timestamp}
// Overflow record:   kind=3'b111, drop count in the low OVF_WIDTH bits, rest 0
// ---------------------------------------------------------------------------
module osd_ctm_sampler #(
    parameter int ADDR_WIDTH = 64,
    parameter int TS_WIDTH   = 32,
    parameter int DEPTH      = 8,
    parameter int OVF_WIDTH  = 16,
    localparam int EW        = 5 + 2*ADDR_WIDTH + TS_WIDTH,
    localparam int LW        = $clog2(DEPTH+1)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cfg_enable,
    input  logic [5:0]            cfg_mask,
    input  logic                  cfg_range_en,
    input  logic [ADDR_WIDTH-1:0] cfg_addr_lo,
    input  logic [ADDR_WIDTH-1:0] cfg_addr_hi,

    input  logic                  stall,

    input  logic                  trace_valid,
    input  logic                  trace_jal,
    input  logic                  trace_jalr,
    input  logic                  trace_branch,
    input  logic                  trace_br_taken,
    input  logic                  trace_trap,
    input  logic                  trace_xcpt,
    input  logic [1:0]            trace_prv,
    input  logic [ADDR_WIDTH-1:0] trace_pc,
    input  logic [ADDR_WIDTH-1:0] trace_npc,

    osd_ctm_sampler_if.master     out_if,

    output logic [LW-1:0]         fifo_level,
    output logic [OVF_WIDTH-1:0]  drop_cnt
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [2:0] KIND_JAL    = 3'd0;
    localparam logic [2:0] KIND_JALR   = 3'd1;
    localparam logic [2:0] KIND_BRANCH = 3'd2;
    localparam logic [2:0] KIND_TRAP   = 3'd3;
    localparam logic [2:0] KIND_XCPT   = 3'd4;
    localparam logic [2:0] KIND_PRV    = 3'd5;
    localparam logic [2:0] KIND_OVF    = 3'd7;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]          prv_reg;
    logic [TS_WIDTH-1:0] ts;

    logic [EW-1:0]       mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [LW-1:0]       count;

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    logic                qual_en;
    logic                in_win;
    logic [5:0]          raw;
    logic [5:0]          hit;
    logic                evt_valid;
    logic [2:0]          evt_kind;
    logic [EW-1:0]       evt_word;
    logic [EW-1:0]       ovf_word;

    logic                full;
    logic                push;
    logic                pop;
    logic [EW-1:0]       push_word;
    logic [OVF_WIDTH-1:0] drop_next;

    // Privilege tracking and timestamp run regardless of cfg_enable, so a
    // privilege change is measured against the level seen in the previous
    // cycle even right after sampling is switched on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prv_reg <= 2'b11;
            ts      <= '0;
        end else begin
            prv_reg <= trace_prv;
            ts      <= ts + 1'b1;
        end
    end

    // Raw event detection and qualification. The PC window only applies to
    // the instruction-related kinds; a privilege change always passes it.
    always_comb begin
        qual_en = cfg_enable & ~stall;
        in_win  = ~cfg_range_en |
                  ((trace_pc >= cfg_addr_lo) && (trace_pc <= cfg_addr_hi));

        raw[0] = trace_valid & trace_jal;
        raw[1] = trace_valid & trace_jalr;
        raw[2] = trace_valid & trace_branch & trace_br_taken;
        raw[3] = trace_valid & trace_trap;
        raw[4] = trace_valid & trace_xcpt;
        raw[5] = (trace_prv != prv_reg);

        hit[4:0] = {5{qual_en & in_win}} & cfg_mask[4:0] & raw[4:0];
        hit[5]   = qual_en & cfg_mask[5] & raw[5];

        evt_valid = |hit;
    end

    // Single-winner selection: prv > xcpt > trap > jalr > jal > branch.
    // Losers in the same cycle are simply discarded, not counted as drops.
    always_comb begin
        evt_kind = KIND_JAL;
        if (hit[5]) begin
            evt_kind = KIND_PRV;
        end else if (hit[4]) begin
            evt_kind = KIND_XCPT;
        end else if (hit[3]) begin
            evt_kind = KIND_TRAP;
        end else if (hit[1]) begin
            evt_kind = KIND_JALR;
        end else if (hit[0]) begin
            evt_kind = KIND_JAL;
        end else if (hit[2]) begin
            evt_kind = KIND_BRANCH;
        end
    end

    assign evt_word = {evt_kind, trace_prv, trace_pc, trace_npc, ts};

    always_comb begin
        ovf_word                  = '0;
        ovf_word[EW-1 -: 3]       = KIND_OVF;
        ovf_word[OVF_WIDTH-1:0]   = drop_cnt;
    end

    // Write arbitration. "full" uses the occupancy at the start of the
    // cycle, so a pop in the same cycle does not open a slot for a push.
    // A pending drop count always goes out first; an event arriving in that
    // same cycle is itself lost and becomes the new count of one.
    always_comb begin
        full      = (count == LW'(DEPTH));
        push      = 1'b0;
        push_word = evt_word;
        drop_next = drop_cnt;

        if (!full) begin
            if (drop_cnt != '0) begin
                push      = 1'b1;
                push_word = ovf_word;
                drop_next = evt_valid ? OVF_WIDTH'(1) : '0;
            end else if (evt_valid) begin
                push      = 1'b1;
            end
        end else if (evt_valid && (drop_cnt != '1)) begin
            drop_next = drop_cnt + 1'b1;
        end
    end

    assign pop = (count != '0) & out_if.out_ready;

    // FIFO bookkeeping. Pointers wrap naturally because DEPTH is a power of
    // two; the separate count distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + LW'(push) - LW'(pop);
        end
    end

    // Storage array carries no reset; stale contents are never exposed
    // because out_data is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

    assign out_if.out_valid = (count != '0);
    assign out_if.out_data  = (count != '0) ? mem[rd_ptr] : '0;
    assign fifo_level       = count;

endmodule

// File: doc/osd_ctm_sampler.md
# osd_ctm_sampler

Parametrised trace-capture front end for the core trace module. It watches the core's retirement trace and qualifies jal, jalr, taken-branch, trap, exception and privilege-change events against a runtime event mask and an optional PC address window. Each qualified event is timestamped and buffered in a DEPTH-entry FIFO. When the FIFO is full, events are counted rather than silently lost, and the count is later emitted as an explicit overflow record. It sits between the core trace port and the trace packetizer, and takes its configuration from the module's register-access layer.

## Interface
- ADDR_WIDTH, 64, width of trace_pc/trace_npc
- TS_WIDTH, 32, timestamp width
- DEPTH, 8, FIFO entries; power of two, at least 2
- OVF_WIDTH, 16, dropped-event counter width; must be ≤ EW-3
- Derived: EW = 5 + 2*ADDR_WIDTH + TS_WIDTH; LW = $clog2(DEPTH+1)

Ports:
- clk  in  1  sole clock
- rst_n  in  1  reset; asynchronous, active-low
- cfg_enable  in  1  sampling enable
- cfg_mask  in  6  per-kind enable, indexed by kind 0..5
- cfg_range_en  in  1  enable the PC window filter
- cfg_addr_lo, cfg_addr_hi  in  ADDR_WIDTH  inclusive PC window
- stall  in  1  suppress qualification; high while the debug system is stalled
- trace_valid, trace_jal, trace_jalr, trace_branch, trace_br_taken, trace_trap, trace_xcpt  in  1  each; core trace strobes
- trace_prv  in  2  current privilege level
- trace_pc, trace_npc  in  ADDR_WIDTH  current PC and next PC
- out_data  out  EW  event word
- out_valid  out  1  event word is valid
- out_ready  in  1  downstream can accept the event word
- fifo_level  out  LW  current FIFO occupancy
- drop_cnt  out  OVF_WIDTH  pending dropped-event count

## Operation
- **Event kinds:**
  - 0: jal
  - 1: jalr
  - 2: taken branch (trace_branch & trace_br_taken)
  - 3: trap
  - 4: exception
  - 5: privilege change
  - 7: overflow record
  - Kinds 0–4 require trace_valid.
- **Privilege tracking:** prv_reg resets to 2'b11 and samples trace_prv every cycle, including while disabled. Kind 5 fires when trace_prv != prv_reg.
- **Qualification:** a kind qualifies when cfg_enable & !stall & cfg_mask[kind].
  - With cfg_range_en=1, kinds 0–4 additionally require cfg_addr_lo ≤ trace_pc ≤ cfg_addr_hi (unsigned compare).
  - Kind 5 bypasses the window filter.
- **Priority:** at most one event per cycle, chosen in the order 5 > 4 > 3 > 1 > 0 > 2. Lower-priority kinds in the same cycle are discarded and are not counted.
- **Event word:** {kind[2:0], prv[1:0], pc, npc, timestamp}.
  - prv is trace_prv.
  - timestamp is a free-running TS_WIDTH counter: resets to 0, increments every cycle, wraps silently.
- **Overflow record:** kind=3'b111, the low OVF_WIDTH bits hold drop_cnt, all other bits are 0.
- **Write arbitration** (push is allowed only when occupancy at cycle start < DEPTH):
  - **drop_cnt != 0 and push allowed:**
    - Push the overflow record.
    - A qualified event in the same cycle is not pushed; drop_cnt becomes 1.
    - Otherwise drop_cnt becomes 0.
  - **drop_cnt == 0, event qualified, push allowed:** push the event.
  - **Event qualified, push not allowed:** drop_cnt increments, saturating at all-ones.
- **FIFO:** first-word fall-through.
  - out_valid = non-empty; out_data is the head entry.
  - A pop occurs when out_valid & out_ready.
  - Push and pop may occur in the same cycle; the level is then unchanged.
  - A pop does not free a slot for a push in the same cycle; a full FIFO stays full-blocked for that cycle.
- **Disable:** deasserting cfg_enable stops new events only. The FIFO keeps draining, and a pending drop_cnt is still flushed as an overflow record.

## Timing
- **Reset:** while rst_n is low, all state clears asynchronously:
  - out_valid=0, out_data=0, fifo_level=0, drop_cnt=0
  - timestamp=0, prv_reg=2'b11
  - FIFO pointers=0
- **Latency:** an event qualified in cycle N is visible on out_data/out_valid in cycle N+1, provided the FIFO was empty. The timestamp value recorded is the counter value in cycle N.
- **Ordering:** out_data is held stable while out_valid & !out_ready. Records leave in push order.
- **Throughput:** 1 event per cycle in steady state with out_ready held high.
- **Pointer wrap:** pointers are log2(DEPTH) bits and wrap naturally. Occupancy is tracked by a separate LW-bit count.
- **Reset mid-stream:** all buffered events and the pending drop count are discarded. There is no spurious privilege event unless trace_prv != 2'b11 after reset.

## Test plan
- **Single event:** reset, cfg_enable=1, cfg_mask=6'h3F, one jal at pc=0x1000, npc=0x2000 → next cycle out_data = {3'd0, prv, 0x1000, 0x2000, ts}, out_valid=1, fifo_level=1.
- **Priority:** trace_prv changes 3→0 in the same cycle as trace_xcpt and trace_jal → exactly one kind-5 record; fifo_level=1.
- **PC window:** cfg_range_en=1, window [0x100, 0x1FF]; jalr events at pc 0xFF, 0x100, 0x1FF, 0x200 → exactly 2 records (pc 0x100, 0x1FF).
- **Overflow with simultaneous event:** DEPTH=8, out_ready=0, 11 qualified jal events → fifo_level=8, drop_cnt=3. Then pop one entry with a jal present in the following cycle → overflow record with count 3 is pushed, drop_cnt=1.
- **Saturation:** OVF_WIDTH=4, FIFO held full, 20 drops → drop_cnt=15. Release out_ready → 8 events, then an overflow record with count 15, in that order.
- **Async reset:** assert rst_n low mid-burst with 5 entries buffered → out_valid=0 and fifo_level=0 immediately, without waiting for a clock edge.
